// File: rtl/rv32_mem_pkg.sv
// Shared types for the RV32 fetch/data memory arbiter.
// FSM states, owner tags and the abort counter width.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Wide enough for any abort limit up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Two-way picker between fetch and data requests.
// Fixed data priority or round-robin on the last owner.
module rv32_rr_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic ireq_i,
  input  logic dreq_i,
  output logic ignt_o,
  output logic dgnt_o
);

  owner_e last_q, last_d;
  logic   i_turn;

  assign i_turn = (RR != 0) && (last_q == OWN_D);
  assign ignt_o = en_i & ireq_i & (~dreq_i | i_turn);
  assign dgnt_o = en_i & dreq_i & ~ignt_o;

  always_comb begin
    last_d = last_q;
    unique case (1'b1)
      ignt_o:  last_d = OWN_I;
      dgnt_o:  last_d = OWN_D;
      default: last_d = last_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= OWN_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Single-outstanding arbiter muxing fetch and data ports
// onto one memory bus, with a bounded wait for m_ack.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 0,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata
);

  localparam int BW = DW / 8;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [BW-1:0]     be_q, be_d;
  logic              irv_q, irv_d;
  logic              drv_q, drv_d;
  logic [DW-1:0]     ird_q, ird_d;
  logic [DW-1:0]     drd_q, drd_d;
  logic              ierr_q, ierr_d;
  logic              derr_q, derr_d;

  logic              busy;
  logic              fin;
  logic              pick_en;
  logic              pick_i;
  logic              pick_d;
  logic [DW-1:0]     rsp_data;

  assign busy    = (state_q != ST_IDLE);
  // Ack on the limit cycle still counts as a clean completion.
  assign fin     = busy && (m_ack || (cnt_q == CNT_W'(TIMEOUT)));
  assign rsp_data = m_ack ? m_rdata : '0;
  assign pick_en = (state_q == ST_IDLE) && reset_n;

  rv32_rr_arbiter #(
    .RR(RR)
  ) u_pick (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (pick_en),
    .ireq_i (i_req),
    .dreq_i (d_req),
    .ignt_o (pick_i),
    .dgnt_o (pick_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    irv_d   = 1'b0;
    drv_d   = 1'b0;
    ird_d   = ird_q;
    drd_d   = drd_q;
    ierr_d  = ierr_q;
    derr_d  = derr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_i) begin
          state_d = ST_BUSY_I;
          cnt_d   = CNT_W'(1);
          we_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
          be_d    = '1;
        end else if (pick_d) begin
          state_d = ST_BUSY_D;
          cnt_d   = CNT_W'(1);
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_be;
        end
      end
      ST_BUSY_I: begin
        if (fin) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          irv_d   = 1'b1;
          ird_d   = rsp_data;
          ierr_d  = ~m_ack;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY_D: begin
        if (fin) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          drv_d   = 1'b1;
          drd_d   = rsp_data;
          derr_d  = ~m_ack;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      irv_q   <= 1'b0;
      drv_q   <= 1'b0;
      ird_q   <= '0;
      drd_q   <= '0;
      ierr_q  <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      irv_q   <= irv_d;
      drv_q   <= drv_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      ierr_q  <= ierr_d;
      derr_q  <= derr_d;
    end
  end

  assign i_gnt    = pick_i;
  assign d_gnt    = pick_d;
  assign i_rvalid = irv_q;
  assign d_rvalid = drv_q;
  assign i_rdata  = ird_q;
  assign d_rdata  = drd_q;
  assign i_err    = ierr_q;
  assign d_err    = derr_q;
  assign m_req    = busy;
  assign m_we     = we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_be     = be_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench: fixed-priority/TIMEOUT=4 instance (a_*)
// and round-robin/default-timeout instance (b_*) on shared inputs.
module tb_rv32_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  logic        a_i_gnt, a_i_rvalid, a_i_err;
  logic [31:0] a_i_rdata;
  logic        a_d_gnt, a_d_rvalid, a_d_err;
  logic [31:0] a_d_rdata;
  logic        a_m_req, a_m_we;
  logic [31:0] a_m_addr, a_m_wdata;
  logic [3:0]  a_m_be;

  logic        b_i_gnt, b_i_rvalid, b_i_err;
  logic [31:0] b_i_rdata;
  logic        b_d_gnt, b_d_rvalid, b_d_err;
  logic [31:0] b_d_rdata;
  logic        b_m_req, b_m_we;
  logic [31:0] b_m_addr, b_m_wdata;
  logic [3:0]  b_m_be;

  int n_chk;
  int n_fail;

  rv32_mem_arbiter #(.RR(0), .TIMEOUT(4)) u_fix (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid),
    .i_rdata(a_i_rdata), .i_err(a_i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid),
    .d_rdata(a_d_rdata), .d_err(a_d_err),
    .m_req(a_m_req), .m_we(a_m_we), .m_addr(a_m_addr),
    .m_wdata(a_m_wdata), .m_be(a_m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  rv32_mem_arbiter #(.RR(1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid),
    .i_rdata(b_i_rdata), .i_err(b_i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
    .d_rdata(b_d_rdata), .d_err(b_d_err),
    .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr),
    .m_wdata(b_m_wdata), .m_be(b_m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;
    m_ack   = 1'b0;
    m_rdata = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // reset state
    do_reset();
    #1;
    check("rst_mreq", a_m_req, 0);
    check("rst_irv", a_i_rvalid, 0);
    check("rst_drv", a_d_rvalid, 0);
    check("rst_addr", a_m_addr, 0);
    check("rst_be", a_m_be, 0);
    check("rst_gnt", {a_i_gnt, a_d_gnt}, 0);

    // fetch, ack two cycles after m_req
    do_reset();
    i_req  = 1'b1;
    i_addr = 32'h100;
    #1;
    check("f_igntc0", a_i_gnt, 1);
    check("f_dgntc0", a_d_gnt, 0);
    step();
    i_req = 1'b0;
    #1;
    check("f_mreq1", a_m_req, 1);
    check("f_maddr", a_m_addr, 32'h100);
    check("f_mwe", a_m_we, 0);
    check("f_mbe", a_m_be, 4'hF);
    step();
    #1;
    check("f_mreq2", a_m_req, 1);
    step();
    m_ack   = 1'b1;
    m_rdata = 32'h13;
    #1;
    check("f_irv3", a_i_rvalid, 0);
    step();
    m_ack = 1'b0;
    #1;
    check("f_irv4", a_i_rvalid, 1);
    check("f_ird4", a_i_rdata, 32'h13);
    check("f_ierr4", a_i_err, 0);
    check("f_mreq4", a_m_req, 0);
    step();
    #1;
    check("f_irv5", a_i_rvalid, 0);

    // fixed priority write vs fetch
    do_reset();
    i_req   = 1'b1;
    i_addr  = 32'h200;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h400;
    d_wdata = 32'hDEADBEEF;
    d_be    = 4'hF;
    #1;
    check("w_dgnt0", a_d_gnt, 1);
    check("w_ignt0", a_i_gnt, 0);
    step();
    d_req = 1'b0;
    #1;
    check("w_mwe1", a_m_we, 1);
    check("w_mwd1", a_m_wdata, 32'hDEADBEEF);
    check("w_madr1", a_m_addr, 32'h400);
    check("w_ignt1", a_i_gnt, 0);
    step();
    m_ack = 1'b1;
    #1;
    check("w_mreq2", a_m_req, 1);
    check("w_mwd2", a_m_wdata, 32'hDEADBEEF);
    step();
    m_ack = 1'b0;
    #1;
    check("w_drv3", a_d_rvalid, 1);
    check("w_derr3", a_d_err, 0);
    check("w_ignt3", a_i_gnt, 1);
    step();
    i_req = 1'b0;
    #1;
    check("w_madr4", a_m_addr, 32'h200);
    check("w_mwe4", a_m_we, 0);

    // round-robin, both requesting, single-cycle ack
    do_reset();
    i_req  = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    m_ack  = 1'b1;
    #1;
    check("rr_fix_d", a_d_gnt, 1);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) #1;
      check($sformatf("rr_i%0d", k), b_i_gnt, (k % 2) == 0);
      check($sformatf("rr_d%0d", k), b_d_gnt, (k % 2) == 1);
      step();
      #1;
      check($sformatf("rr_busy%0d", k), {b_i_gnt, b_d_gnt}, 0);
      step();
    end

    // back-to-back read then timeout
    do_reset();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h80;
    #1;
    check("to_dgnt0", a_d_gnt, 1);
    step();
    m_ack   = 1'b1;
    m_rdata = 32'h55;
    step();
    m_ack = 1'b0;
    #1;
    check("to_drv2", a_d_rvalid, 1);
    check("to_drd2", a_d_rdata, 32'h55);
    check("to_dgnt2", a_d_gnt, 1);
    step();
    d_req = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      #1;
      check($sformatf("to_mreq%0d", n), a_m_req, 1);
      step();
    end
    #1;
    check("to_mreq_end", a_m_req, 0);
    check("to_drv", a_d_rvalid, 1);
    check("to_derr", a_d_err, 1);
    check("to_drd", a_d_rdata, 0);

    // ack on the limit cycle wins
    do_reset();
    i_req  = 1'b1;
    i_addr = 32'h300;
    #1;
    check("lim_ignt", a_i_gnt, 1);
    step();
    i_req = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      #1;
      check($sformatf("lim_mreq%0d", n), a_m_req, 1);
      step();
    end
    m_ack   = 1'b1;
    m_rdata = 32'hCAFE0001;
    #1;
    check("lim_mreq4", a_m_req, 1);
    step();
    m_ack = 1'b0;
    #1;
    check("lim_irv", a_i_rvalid, 1);
    check("lim_ierr", a_i_err, 0);
    check("lim_ird", a_i_rdata, 32'hCAFE0001);

    // reset mid-fetch, then stray ack in idle
    do_reset();
    i_req  = 1'b1;
    i_addr = 32'h500;
    step();
    i_req = 1'b0;
    #1;
    check("mr_mreq1", a_m_req, 1);
    reset_n = 1'b0;
    step();
    #1;
    check("mr_mreq2", a_m_req, 0);
    check("mr_irv2", a_i_rvalid, 0);
    check("mr_addr2", a_m_addr, 0);
    check("mr_be2", a_m_be, 0);
    reset_n = 1'b1;
    step();
    #1;
    check("mr_irv3", a_i_rvalid, 0);
    m_ack   = 1'b1;
    m_rdata = 32'h77;
    step();
    m_ack = 1'b0;
    #1;
    check("ig_irv", a_i_rvalid, 0);
    check("ig_drv", a_d_rvalid, 0);
    check("ig_ird", a_i_rdata, 0);
    check("ig_mreq", a_m_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
